// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (IF) and the
// M stage (DM). One transfer is outstanding at a time. DM wins contested
// grants until FAIR_MAX DM grants in a row have been made while IF was
// waiting; the next contested grant then goes to IF.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   if_req/if_addr                  fetch read request
//   if_ack/if_rdata                 fetch completion pulse + instruction word
//   dm_req/dm_write/dm_byteword     M-stage request and its control bits
//   dm_addr/dm_wdata                M-stage address / store data
//   dm_ack/dm_rdata                 M-stage completion pulse + load data
//   err                             pulses with the ack of a timed-out transfer
//   mem_req/mem_write/mem_byteword  memory request, held until mem_ready
//   mem_addr/mem_wdata              memory address / write data
//   mem_rdata/mem_ready             memory read data and completion
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int FAIR_MAX = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_write,
    input  logic              dm_byteword,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_write,
    output logic              mem_byteword,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int FW = $clog2(FAIR_MAX + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [FW-1:0] FAIR_TOP = FW'(FAIR_MAX);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state, state_nx;
    logic [FW-1:0] fair_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          owner_dm;
    logic          start, grant_dm, done_ok, done_to;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        grant_dm = 1'b0;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        case (state)
            IDLE: if (dm_req || if_req) begin
                start    = 1'b1;
                grant_dm = dm_req && !(if_req && fair_cnt == FAIR_TOP);
                state_nx = REQ;
            end
            // mem_ready wins over a timeout landing in the same cycle
            REQ: if (mem_ready) begin
                done_ok  = 1'b1;
                state_nx = RESP;
            end else if (tmo_cnt == TMO_LAST) begin
                done_to  = 1'b1;
                state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fair_cnt     <= '0;
            tmo_cnt      <= '0;
            owner_dm     <= 1'b0;
            mem_req      <= 1'b0;
            mem_write    <= 1'b0;
            mem_byteword <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_ack       <= 1'b0;
            dm_ack       <= 1'b0;
            if_rdata     <= '0;
            dm_rdata     <= '0;
            err          <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            err    <= 1'b0;
            if (start) begin
                // fetch is always a word read
                mem_req      <= 1'b1;
                mem_write    <= grant_dm & dm_write;
                mem_byteword <= grant_dm ? dm_byteword : 1'b1;
                mem_addr     <= grant_dm ? dm_addr : if_addr;
                mem_wdata    <= grant_dm ? dm_wdata : '0;
                owner_dm     <= grant_dm;
                tmo_cnt      <= '0;
                // only a DM grant that made fetch wait counts toward fairness
                if (grant_dm && if_req) begin
                    if (fair_cnt != FAIR_TOP) fair_cnt <= fair_cnt + 1'b1;
                end else begin
                    fair_cnt <= '0;
                end
            end
            if (state == REQ) begin
                if (done_ok || done_to) begin
                    mem_req <= 1'b0;
                    err     <= done_to;
                    if (owner_dm) begin
                        dm_ack   <= 1'b1;
                        dm_rdata <= done_ok ? mem_rdata : '0;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= done_ok ? mem_rdata : '0;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that shares the single unified memory port between the fetch stage (instruction reads) and the M stage (loads/stores driven by the decode-stage `memread`/`memwrite`/`byteword` control bits). One transfer is outstanding at a time. Grants favour the M stage, with a fairness counter that bounds fetch starvation. Completion is returned to each requester as a one-cycle ack with read data; the pipeline uses req-without-ack as its stall source.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `FAIR_MAX`, 4, consecutive contested M-stage grants before fetch is forced; must be ≥1
- `TIMEOUT`, 64, cycles to wait for `mem_ready` before aborting; must be ≥2

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch read request (level)
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle completion pulse to fetch
- `if_rdata`  out  DATA_W  instruction word, valid while `if_ack`=1
- `dm_req`  in  1  M-stage request (level), = memread|memwrite
- `dm_write`  in  1  1=store, 0=load
- `dm_byteword`  in  1  0=byte, 1=word
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_ack`  out  1  one-cycle completion pulse to M stage
- `dm_rdata`  out  DATA_W  load data, valid while `dm_ack`=1
- `err`  out  1  one-cycle pulse, coincident with the ack of a timed-out transfer
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_write`  out  1  memory write enable
- `mem_byteword`  out  1  memory byte/word select
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completion, sampled only while `mem_req`=1

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE
  - If `dm_req`|`if_req`, arbitrate and latch the winner's addr/wdata/write/byteword into output registers. Fetch always uses write=0, byteword=1.
  - Latch the grant owner. Go to REQ.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only `dm_req` set: grant DM.
  - Only `if_req` set: grant IF.
  - Both set: grant IF if `fair_cnt`==FAIR_MAX, else DM.
- `fair_cnt` (0..FAIR_MAX):
  - Increments on a DM grant made while `if_req`=1.
  - Clears on any IF grant, or on a DM grant made while `if_req`=0.
  - Saturates at FAIR_MAX.
- REQ
  - `mem_req`=1 and all mem_* outputs held stable.
  - Timeout counter increments each cycle.
  - `mem_ready`=1: capture `mem_rdata` into the owner's rdata register, drop `mem_req`, go to RESP.
  - Counter reaches TIMEOUT-1 with no `mem_ready`: drop `mem_req`, set rdata to 0, flag error, go to RESP.
- RESP
  - Owner's ack=1 for exactly one cycle; `err`=1 if the transfer timed out.
  - The non-owner's ack stays 0.
  - Next state is IDLE.
- Requester rule: a requester must drop or change its req in the cycle after its ack. A req still high in IDLE is a new transfer.
- Read data is passed through unmodified; byte extraction and extension are the M stage's job. For stores, rdata is don't-care but the ack is still issued.
- The arbiter ignores a requester's req changes while that requester is not being sampled in IDLE.

## Timing
- Reset values (asynchronous):
  - state=IDLE, `fair_cnt`=0, timeout counter=0.
  - All outputs 0: `mem_req`, `mem_write`, `mem_byteword`, `mem_addr`, `mem_wdata`, acks, rdatas, `err`.
- Latency:
  - req sampled in IDLE in cycle 0.
  - `mem_req`=1 from cycle 1.
  - `mem_ready` in cycle k≥1.
  - Ack in cycle k+1.
  - Minimum 3-cycle turnaround; back-to-back transfers start every k+2 cycles.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); ack+`err` follow in cycle TIMEOUT+1.
- `mem_ready` outside REQ is ignored.
- `mem_ready` arriving in the same cycle the timeout would fire counts as success (`err`=0).
- Reset mid-transfer:
  - `mem_req` drops immediately and no ack is issued.
  - The memory must tolerate an abandoned request.
  - Requesters re-issue after reset.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Single fetch, `mem_ready` in cycle 1:
  - Stimulus: `if_req`=1, `if_addr`=0x1000 in cycle 0; `mem_rdata`=0xDEADBEEF.
  - Response: `mem_req`=1, `mem_addr`=0x1000, `mem_write`=0 in cycle 1; `if_ack`=1 with `if_rdata`=0xDEADBEEF in cycle 2; `dm_ack` stays 0.
- Byte store with 3-cycle memory:
  - Stimulus: `dm_req`=1, `dm_write`=1, `dm_byteword`=0, `dm_addr`=0x2003, `dm_wdata`=0xAB; `mem_ready` in cycle 3.
  - Response: mem_* outputs stable over cycles 1–3; `dm_ack` in cycle 4.
- Contention and fairness, FAIR_MAX=4:
  - Stimulus: both reqs held high continuously.
  - Response: grant order DM,DM,DM,DM,IF,DM,…; fetch never waits more than 4 DM transfers.
- Timeout, TIMEOUT=8:
  - Stimulus: `mem_ready` never asserted.
  - Response: `mem_req` high cycles 1–8; owner ack with rdata=0 and `err`=1 in cycle 9; return to IDLE.
- Reset mid-transfer:
  - Stimulus: assert `reset` in cycle 2 of a load (before `mem_ready`).
  - Response: `mem_req`=0 immediately and all outputs 0; no ack issued. After reset release, a new fetch completes normally.
- Ready/timeout coincidence:
  - Stimulus: TIMEOUT=8, `mem_ready` in cycle 8.
  - Response: normal ack in cycle 9 with captured data and `err`=0.
